uart_hex_streamer: RTL and testbench
====================================

Name: uart_hex_streamer

Overview:
- Parametrised successor to the fixed 32-bit ROM hex-dump loop in the top level.
- Accepts DATA_W-bit words over a valid/ready interface and buffers them in an internal FIFO.
- Serialises each word as uppercase ASCII hex, followed by a configurable line ending, into the existing uart_tx byte interface (write_en/data/uart_busy).
- Sits between pc_one debug/trace sources and uart_tx.

Parameters:
- DATA_W, 32: word width; multiple of 4, range 4..64.
- FIFO_DEPTH, 8: word FIFO depth; power of 2, 2..64.
- EOL_MODE, 2: line ending. 0 = none, 1 = LF (0x0A), 2 = CR LF (0x0D 0x0A).

Ports:
- clk_from_FPGA  in  1  single clock.
- rst_from_FPGA  in  1  synchronous, active-high reset.
- in_valid  in  1  producer word valid.
- in_data  in  DATA_W  producer word.
- in_ready  out  1  FIFO not full.
- tx_write_en  out  1  one-cycle byte strobe to uart_tx.
- tx_data  out  8  ASCII byte to uart_tx.
- tx_busy  in  1  uart_tx busy.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO (excludes the word in flight).
- overflow  out  1  sticky; a word was offered while the FIFO was full.
- idle  out  1  FSM in IDLE and FIFO empty.

Behaviour:
- Reset (synchronous, takes effect at the next clk edge with rst_from_FPGA=1):
  - FIFO emptied; fifo_count=0; in_ready=1.
  - tx_write_en=0; tx_data=8'h00; overflow=0; idle=1; FSM=IDLE; char index=0.
  - Reset mid-word aborts: the word in flight and all buffered words are discarded, and no further strobe is issued.
- FIFO:
  - Push on in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), combinational.
  - in_valid && !in_ready sets overflow; it is cleared only by reset. The offered word is dropped.
  - Pop only on the IDLE->ISSUE transition. Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Character sequence per word, NIB = DATA_W/4:
  - Nibbles are sent MSB first: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
  - Then the EOL bytes per EOL_MODE.
  - Total chars = NIB + EOL_MODE (+2 with the optional feature).
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE: if FIFO not empty, pop the head into word_latched, index=0, go to ISSUE.
  - ISSUE (exactly 1 cycle): tx_write_en=1 and tx_data=char[index], both registered, valid in this cycle. Go to WAIT_ACK.
  - WAIT_ACK: stay while tx_busy=0; on tx_busy=1 go to WAIT_DONE. The strobe is not repeated.
  - WAIT_DONE: stay while tx_busy=1. On tx_busy=0: if index is the last char, go to IDLE; else index+1 and go to ISSUE.
- Latency: word pushed at edge N -> IDLE pops at edge N+1 -> tx_write_en high during cycle N+1..N+2 (the first ISSUE cycle).
- tx_write_en is never high in two consecutive cycles.
- tx_data holds its last value outside ISSUE.
- Back-to-back words: the next pop occurs in the IDLE cycle following the last char's WAIT_DONE exit. There is no extra gap beyond that one IDLE cycle.
- idle = (state==IDLE) && (fifo_count==0).

Optional Feature:
- Macro: UART_HEX_STREAMER_PREFIX_EN.
- Defined: each word is preceded by "0x" (0x30, 0x78). These 2 chars are issued through the same ISSUE/WAIT handshake before the nibbles.
- Undefined: no prefix; the char sequence is nibbles + EOL only.

Test Plan:
- 32'hDEADBEEF, EOL_MODE=2, uart model raises busy 1 cycle after strobe for 10 cycles -> 10 strobes carrying 44,45,41,44,42,45,45,46,0D,0A (hex), then idle=1.
- 32'h0123ABCD -> bytes 30,31,32,33,41,42,43,44,0D,0A; confirms digit/letter boundary mapping.
- tx_busy held at 1, offer 10 consecutive words -> 9 accepted (1 in flight + 8 buffered), fifo_count=8, in_ready=0; 10th word sets overflow=1, which stays 1 after busy releases.
- Reset asserted after 3rd char of a word with 2 words buffered -> no strobe after the reset edge, fifo_count=0, in_ready=1, overflow=0, idle=1.
- DATA_W=8, EOL_MODE=0, word 8'h5A -> exactly 2 strobes: 35, 41.
- UART_HEX_STREAMER_PREFIX_EN defined, 32'h00000001, EOL_MODE=2 -> 12 strobes: 30,78,30,30,30,30,30,30,30,31,0D,0A.

Source files
------------

// File: rtl/uart_hex_streamer.sv
// uart_hex_streamer: buffers words in a FIFO and streams them to uart_tx as uppercase ASCII hex plus EOL
// Optional "0x" prefix per word when UART_HEX_STREAMER_PREFIX_EN is defined.
module uart_hex_streamer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int EOL_MODE   = 2
) (
    input  logic                          clk_from_FPGA,
    input  logic                          rst_from_FPGA,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          tx_write_en,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          idle
);
`ifdef UART_HEX_STREAMER_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif
    localparam int NIB = DATA_W / 4;
    localparam int NCH = PFX + NIB + EOL_MODE;
    localparam int IW  = $clog2(NCH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [DATA_W-1:0]   r_word;
    logic [IW-1:0]       r_idx;
    logic                r_tx_we;
    logic [7:0]          r_tx_data;
    logic                r_overflow;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic [DATA_W-1:0]   w_char_word;
    logic [IW-1:0]       w_char_idx;
    logic [7:0]          w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // prefix chars, then nibbles MSB first, then line ending
    function automatic logic [7:0] char_at(input logic [DATA_W-1:0] word, input int idx);
        int k;
        if (idx < PFX) return (idx == 0) ? 8'h30 : 8'h78;
        if (idx < PFX + NIB) begin
            k = NIB - 1 - (idx - PFX);
            return hex_ascii(word[4*k +: 4]);
        end
        return (EOL_MODE == 2 && idx == PFX + NIB) ? 8'h0D : 8'h0A;
    endfunction

    // combinational outputs, FIFO handshakes and the next character to issue
    always_comb begin
        in_ready    = (r_count != CW'(FIFO_DEPTH));
        w_push      = in_valid && in_ready;
        w_pop       = (r_state == IDLE) && (r_count != '0);
        w_last      = (r_idx == IW'(NCH - 1));
        w_char_word = w_pop ? r_mem[r_rd_ptr] : r_word;
        w_char_idx  = w_pop ? '0 : r_idx + IW'(1);
        w_char      = char_at(w_char_word, int'(w_char_idx));
        idle        = (r_state == IDLE) && (r_count == '0);
        tx_write_en = r_tx_we;
        tx_data     = r_tx_data;
        overflow    = r_overflow;
        fifo_count  = r_count;
    end

    // next-state: one ISSUE cycle per char, then wait for uart_tx busy to rise and fall
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_pop) w_state_next = ISSUE;
            ISSUE:     w_state_next = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) w_state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) w_state_next = w_last ? IDLE : ISSUE;
            default:   w_state_next = IDLE;
        endcase
    end

    // state, FIFO pointers/count, and registered strobe/byte loaded on entry to ISSUE
    always_ff @(posedge clk_from_FPGA) begin
        if (rst_from_FPGA) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_idx      <= '0;
            r_tx_we    <= 1'b0;
            r_tx_data  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx_we <= (w_state_next == ISSUE);
            if (w_state_next == ISSUE) begin
                r_tx_data <= w_char;
                r_idx     <= w_char_idx;
            end
            if (w_pop) begin
                r_word   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (in_valid && !in_ready) r_overflow <= 1'b1;
        end
    end

    // FIFO storage needs no reset; only valid entries are ever read
    always_ff @(posedge clk_from_FPGA) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_uart_hex_streamer.sv
// tb_uart_hex_streamer: directed self-checking bench for uart_hex_streamer
module tb_uart_hex_streamer;
`ifdef UART_HEX_STREAMER_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif
    localparam int CPW = PFX + 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        tx_write_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        idle;
    logic        force_busy = 1'b0;
    int          bcnt = 0;

    logic        v8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        rdy8;
    logic        we8;
    logic [7:0]  data8;
    logic        busy8;
    logic [3:0]  cnt8;
    logic        ovf8;
    logic        idle8;
    int          bcnt8 = 0;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          consec = 0;
    logic        prev_we = 1'b0;
    logic [7:0]  cap[$];
    int          cap_t[$];
    logic [7:0]  cap8[$];

    always #5 clk = ~clk;

    uart_hex_streamer #(.DATA_W(32), .FIFO_DEPTH(8), .EOL_MODE(2)) dut (
        .clk_from_FPGA(clk), .rst_from_FPGA(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_write_en(tx_write_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow), .idle(idle)
    );

    uart_hex_streamer #(.DATA_W(8), .FIFO_DEPTH(8), .EOL_MODE(0)) dut8 (
        .clk_from_FPGA(clk), .rst_from_FPGA(rst), .in_valid(v8), .in_data(d8),
        .in_ready(rdy8), .tx_write_en(we8), .tx_data(data8), .tx_busy(busy8),
        .fifo_count(cnt8), .overflow(ovf8), .idle(idle8)
    );

    assign tx_busy = force_busy || (bcnt != 0);
    assign busy8   = (bcnt8 != 0);

    // uart_tx model: busy for 10 cycles starting the cycle after a strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bcnt  <= tx_write_en ? 10 : (bcnt != 0 ? bcnt - 1 : 0);
        bcnt8 <= we8 ? 10 : (bcnt8 != 0 ? bcnt8 - 1 : 0);
    end

    // byte capture
    always @(negedge clk) begin
        if (tx_write_en) begin
            cap.push_back(tx_data);
            cap_t.push_back(cyc);
        end
        if (we8) cap8.push_back(data8);
        if (tx_write_en && prev_we) consec++;
        prev_we = tx_write_en;
    end

    task automatic push_word(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cap(input int n, input int limit);
        for (int i = 0; i < limit && cap.size() < n; i++) @(posedge clk);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && !idle; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        total++; if (tx_write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", tx_write_en); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        rst = 1'b0;
    endtask

    task automatic test_word(input string name, input logic [31:0] w, input logic [7:0] body [10]);
        logic [7:0] exp[$];
        for (int i = 0; i < 10; i++) exp.push_back(body[i]);
`ifdef UART_HEX_STREAMER_PREFIX_EN
        exp.push_front(8'h78);
        exp.push_front(8'h30);
`endif
        cap.delete();
        cap_t.delete();
        push_word(w);
        total++; if (tx_write_en !== 1'b0) begin bad++; $display("FAIL %s_lat0 we=%b exp=0", name, tx_write_en); end
        @(negedge clk);
        total++; if (tx_write_en !== 1'b1 || tx_data !== exp[0]) begin bad++; $display("FAIL %s_lat1 we=%b data=%h exp we=1 data=%h", name, tx_write_en, tx_data, exp[0]); end
        wait_cap(exp.size(), 1000);
        wait_idle(100);
        total++; if (cap.size() !== exp.size()) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", name, cap.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= cap.size() || cap[i] !== exp[i]) begin
                bad++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, (i < cap.size()) ? cap[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL %s_idle got=%b exp=1", name, idle); end
    endtask

    task automatic test_overflow;
        cap.delete();
        force_busy = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'(32'h11111111 * i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", in_ready); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        force_busy = 1'b0;
        wait_cap(9 * CPW, 3000);
        wait_idle(100);
        total++; if (cap.size() !== 9 * CPW) begin bad++; $display("FAIL ovf_strobes got=%0d exp=%0d", cap.size(), 9 * CPW); end
        for (int w = 0; w < 9; w++) begin
            total++;
            if (w * CPW + PFX + 7 >= cap.size() || cap[w*CPW+PFX+7] !== 8'(8'h31 + w)) begin
                bad++; $display("FAIL ovf_order%0d exp=%h", w, 8'(8'h31 + w));
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_midword_reset;
        cap.delete();
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hCAFE0000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_cap(3, 200);
        total++; if (cap.size() !== 3) begin bad++; $display("FAIL mid_pre got=%0d exp=3", cap.size()); end
        total++; if (fifo_count !== 4'd2) begin bad++; $display("FAIL mid_buf got=%0d exp=2", fifo_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cap.delete();
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle got=%b exp=1", idle); end
        repeat (100) @(posedge clk);
        total++; if (cap.size() !== 0) begin bad++; $display("FAIL mid_nostrobe got=%0d exp=0", cap.size()); end
    endtask

    task automatic test_narrow;
        logic [7:0] exp[$];
        exp = '{8'h35, 8'h41};
`ifdef UART_HEX_STREAMER_PREFIX_EN
        exp.push_front(8'h78);
        exp.push_front(8'h30);
`endif
        cap8.delete();
        @(negedge clk);
        v8 = 1'b1;
        d8 = 8'h5A;
        @(negedge clk);
        v8 = 1'b0;
        repeat (200) @(posedge clk);
        total++; if (cap8.size() !== exp.size()) begin bad++; $display("FAIL narrow_count got=%0d exp=%0d", cap8.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= cap8.size() || cap8[i] !== exp[i]) begin
                bad++; $display("FAIL narrow_byte%0d got=%h exp=%h", i, (i < cap8.size()) ? cap8[i] : 8'hxx, exp[i]);
            end
        end
        total++; if (idle8 !== 1'b1) begin bad++; $display("FAIL narrow_idle got=%b exp=1", idle8); end
    endtask

    task automatic test_back_to_back;
        cap.delete();
        cap_t.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        @(negedge clk);
        in_data  = 32'h9ABCDEF0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cap(2 * CPW, 1000);
        wait_idle(100);
        total++; if (cap.size() !== 2 * CPW) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", cap.size(), 2 * CPW); end
        if (cap.size() == 2 * CPW) begin
            total++; if (cap_t[1] - cap_t[0] !== 12) begin bad++; $display("FAIL b2b_intra got=%0d exp=12", cap_t[1] - cap_t[0]); end
            total++; if (cap_t[CPW] - cap_t[CPW-1] !== 13) begin bad++; $display("FAIL b2b_inter got=%0d exp=13", cap_t[CPW] - cap_t[CPW-1]); end
            total++; if (cap[PFX] !== 8'h31) begin bad++; $display("FAIL b2b_first got=%h exp=31", cap[PFX]); end
            total++; if (cap[CPW+PFX] !== 8'h39) begin bad++; $display("FAIL b2b_second got=%h exp=39", cap[CPW+PFX]); end
            total++; if (cap[CPW+PFX+7] !== 8'h30) begin bad++; $display("FAIL b2b_last got=%h exp=30", cap[CPW+PFX+7]); end
        end
        total++; if (consec !== 0) begin bad++; $display("FAIL consecutive_strobes got=%0d exp=0", consec); end
    endtask

    initial begin
        logic [7:0] v_dead [10];
        logic [7:0] v_dig [10];
        v_dead = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        v_dig  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        test_reset();
        test_word("deadbeef", 32'hDEADBEEF, v_dead);
        test_word("digits", 32'h0123ABCD, v_dig);
        test_overflow();
        test_midword_reset();
        test_narrow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
